alu_op_sequencer: RTL and testbench

//  Sequenced front-end for the 16-bit signed ALU (add/sub/mul/div/mod).

---
 rtl/alu_op_sequencer.sv | 172 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Sequenced front-end for a signed ALU: single-cycle add/sub/mul, WIDTH-step restoring
// divider for div/mod, one command in flight, results held on a valid/ready port.
module alu_op_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [3:0]           cmd_op,
  input  logic [WIDTH-1:0]     cmd_a,
  input  logic [WIDTH-1:0]     cmd_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [2*WIDTH-1:0]   res_data,
  output logic [1:0]           res_err,
  output logic                 busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   STEP = CW'(1);

  logic [1:0]           state;
  logic                 is_mod;
  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH:0]       divisor;
  logic [WIDTH:0]       rem;
  logic [WIDTH-1:0]     quo;
  logic [CW-1:0]        count;

  // Magnitude in WIDTH+1 bits so the most negative operand has an exact absolute value.
  function automatic logic [WIDTH:0] mag(input logic signed [WIDTH-1:0] v);
    logic signed [WIDTH:0] ext;
    ext = {v[WIDTH-1], v};
    return v[WIDTH-1] ? -ext : ext;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  logic                      sub_op;
  logic [WIDTH-1:0]          addend;
  logic [WIDTH:0]            full_sum;
  logic                      add_ovf;
  logic [2*WIDTH-1:0]        sum_ext;
  logic signed [2*WIDTH-1:0] a_ext;
  logic signed [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0]        prod;
  logic [WIDTH:0]            mag_a;
  logic [WIDTH:0]            mag_b;
  logic                      unused_mag_msb;

  // Accept-cycle arithmetic on the raw command operands.
  always_comb begin
    sub_op   = (cmd_op == 4'd1);
    addend   = sub_op ? ~cmd_b : cmd_b;
    full_sum = {1'b0, cmd_a} + {1'b0, addend} + {{WIDTH{1'b0}}, sub_op};
    // carry into MSB recovered from the MSB sum bit, XOR carry out of MSB
    add_ovf  = (full_sum[WIDTH-1] ^ cmd_a[WIDTH-1] ^ addend[WIDTH-1]) ^ full_sum[WIDTH];
    sum_ext  = {{WIDTH{full_sum[WIDTH-1]}}, full_sum[WIDTH-1:0]};
    a_ext    = {{WIDTH{cmd_a[WIDTH-1]}}, cmd_a};
    b_ext    = {{WIDTH{cmd_b[WIDTH-1]}}, cmd_b};
    prod     = a_ext * b_ext;
    mag_a    = mag(cmd_a);
    mag_b    = mag(cmd_b);
  end

  // |a| never exceeds 2^(WIDTH-1), so its top bit is always clear.
  assign unused_mag_msb = mag_a[WIDTH];

  logic [WIDTH:0]       rem_sh;
  logic [WIDTH:0]       rem_next;
  logic [WIDTH-1:0]     quo_next;
  logic [2*WIDTH-1:0]   quo_signed;
  logic [2*WIDTH-1:0]   rem_signed;

  // One restoring step, plus the sign fix-up applied in FIX.
  always_comb begin
    rem_sh = {rem[WIDTH-1:0], quo[WIDTH-1]};
    if (rem_sh >= divisor) begin
      rem_next = rem_sh - divisor;
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = rem_sh;
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
    quo_signed = cond_neg({{WIDTH{1'b0}}, quo}, a_neg ^ b_neg);
    rem_signed = cond_neg({{(WIDTH-1){1'b0}}, rem}, a_neg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      is_mod   <= 1'b0;
      a_neg    <= 1'b0;
      b_neg    <= 1'b0;
      divisor  <= '0;
      rem      <= '0;
      quo      <= '0;
      count    <= '0;
      res_data <= '0;
      res_err  <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              4'd0, 4'd1: begin
                res_data <= sum_ext;
                res_err  <= {1'b0, add_ovf};
                state    <= DONE;
              end
              4'd2: begin
                res_data <= prod;
                res_err  <= 2'b00;
                state    <= DONE;
              end
              4'd3, 4'd4: begin
                if (cmd_b == '0) begin
                  res_data <= '0;
                  res_err  <= 2'b10;
                  state    <= DONE;
                end else begin
                  is_mod  <= (cmd_op == 4'd4);
                  a_neg   <= cmd_a[WIDTH-1];
                  b_neg   <= cmd_b[WIDTH-1];
                  divisor <= mag_b;
                  quo     <= mag_a[WIDTH-1:0];
                  rem     <= '0;
                  count   <= '0;
                  state   <= DIV;
                end
              end
              default: begin
                res_data <= '0;
                res_err  <= 2'b11;
                state    <= DONE;
              end
            endcase
          end
        end
        DIV: begin
          rem   <= rem_next;
          quo   <= quo_next;
          count <= count + STEP;
          if (count == LAST) state <= FIX;
        end
        FIX: begin
          res_data <= is_mod ? rem_signed : quo_signed;
          res_err  <= 2'b00;
          state    <= DONE;
        end
        default: begin
          if (res_ready) state <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign res_valid = (state == DONE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized bench for alu_op_sequencer against an arithmetic reference model with a
// per-cycle compare process covering handshake, latency, held results and reset values.
module tb_alu_op_sequencer;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [3:0]     cmd_op = 4'd0;
  logic [W-1:0]   cmd_a = '0;
  logic [W-1:0]   cmd_b = '0;
  logic           res_valid;
  logic           res_ready = 1'b1;
  logic [2*W-1:0] res_data;
  logic [1:0]     res_err;
  logic           busy;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int rr_mode = 0;

  logic        pending = 1'b0;
  logic [31:0] exp_data = '0;
  logic [1:0]  exp_err = '0;
  int          exp_cycle = 0;

  alu_op_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic; lat counts cycles from accept to first res_valid.
  function automatic void model(input logic [3:0] op, input logic signed [15:0] a,
                                input logic signed [15:0] b, output logic [31:0] d,
                                output logic [1:0] e, output int lat);
    longint sa, sb, r;
    logic signed [15:0] w;
    sa = a;
    sb = b;
    lat = 1;
    e = 2'b00;
    d = '0;
    case (op)
      4'd0, 4'd1: begin
        r = (op == 4'd0) ? sa + sb : sa - sb;
        e = (r > 32767 || r < -32768) ? 2'b01 : 2'b00;
        w = 16'(r);
        d = {{16{w[15]}}, w};
      end
      4'd2: d = 32'(sa * sb);
      4'd3, 4'd4: begin
        if (sb == 0) e = 2'b10;
        else begin
          d = 32'((op == 4'd3) ? sa / sb : sa % sb);
          lat = 18;
        end
      end
      default: e = 2'b11;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pin(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                     input logic [31:0] ed, input logic [1:0] ee, input int el);
    logic [31:0] d;
    logic [1:0] e;
    int l;
    model(op, a, b, d, e, l);
    chk("model_pin_data", d, ed);
    chk("model_pin_err", {30'd0, e}, {30'd0, ee});
    chk("model_pin_lat", l, el);
  endtask

  always begin
    @(posedge clk);
    #2;
    case (rr_mode)
      0: res_ready = 1'b1;
      1: res_ready = ($urandom_range(0, 3) != 0);
      default: res_ready = 1'b0;
    endcase
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    logic [31:0] d;
    logic [1:0] e;
    int l;
    if (!rst_n) begin
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_res_err", res_err, 0);
      chk("rst_busy", busy, 0);
      pending = 1'b0;
    end else begin
      chk("busy_vs_ready", busy, !cmd_ready);
      if (pending) begin
        chk("cmd_ready_while_busy", cmd_ready, 0);
        chk("res_valid_timing", res_valid, cyc >= exp_cycle);
        if (res_valid) begin
          chk("res_data", res_data, exp_data);
          chk("res_err", res_err, exp_err);
          if (res_ready) pending = 1'b0;
        end
      end else begin
        chk("res_valid_idle", res_valid, 0);
        chk("cmd_ready_idle", cmd_ready, 1);
        if (cmd_valid) begin
          model(cmd_op, cmd_a, cmd_b, d, e, l);
          exp_data  = d;
          exp_err   = e;
          exp_cycle = cyc + l;
          pending   = 1'b1;
        end
      end
    end
  end

  // Tasks start and end 1ns after a rising edge.
  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int n;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    cmd_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!cmd_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (pending && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (pending) chk("done_timeout", 0, 1);
  endtask

  function automatic logic [15:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      4: return 16'h0001;
      default: return 16'($urandom());
    endcase
  endfunction

  initial begin
    int n;
    logic [3:0] op;

    pin(4'd0, 16'd11, 16'd15, 32'd26, 2'b00, 1);
    pin(4'd1, 16'd32000, 16'hC180, 32'hFFFFBB80, 2'b01, 1);
    pin(4'd2, 16'd32000, 16'd16000, 32'd512000000, 2'b00, 1);
    pin(4'd2, 16'hFFFD, 16'd5, 32'hFFFFFFF1, 2'b00, 1);
    pin(4'd3, 16'hFFF9, 16'd2, 32'hFFFFFFFD, 2'b00, 18);
    pin(4'd4, 16'hFFF9, 16'd2, 32'hFFFFFFFF, 2'b00, 18);
    pin(4'd3, 16'h8000, 16'hFFFF, 32'h00008000, 2'b00, 18);
    pin(4'd3, 16'd11, 16'd0, 32'd0, 2'b10, 1);
    pin(4'd9, 16'd1, 16'd2, 32'd0, 2'b11, 1);

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(4'd0, 16'd11, 16'd15);        wait_done();
    send(4'd1, 16'd32000, 16'hC180);   wait_done();
    send(4'd2, 16'd32000, 16'd16000);  wait_done();
    send(4'd2, 16'hFFFD, 16'd5);       wait_done();
    send(4'd3, 16'hFFF9, 16'd2);       wait_done();
    send(4'd4, 16'hFFF9, 16'd2);       wait_done();
    send(4'd3, 16'h8000, 16'hFFFF);    wait_done();
    send(4'd4, 16'h8000, 16'hFFFF);    wait_done();
    send(4'd3, 16'd11, 16'd0);         wait_done();
    send(4'd9, 16'd3, 16'd4);          wait_done();
    send(4'd0, 16'h7FFF, 16'd1);       wait_done();
    send(4'd1, 16'h8000, 16'd1);       wait_done();

    // Result held under back-pressure while stray commands are offered.
    rr_mode = 2;
    send(4'd3, 16'd30000, 16'hFFF9);
    n = 0;
    while (!res_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (5) begin
      cmd_valid = 1'b1;
      cmd_op = 4'd0;
      cmd_a = 16'($urandom());
      cmd_b = 16'($urandom());
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    rr_mode = 0;
    wait_done();

    // Asynchronous reset in the middle of a division (count == 7).
    send(4'd3, 16'd1000, 16'd7);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(4'd1, 16'd5, 16'd9);          wait_done();
    send(4'd4, 16'd1000, 16'd7);       wait_done();

    rr_mode = 1;
    for (int i = 0; i < 250; i++) begin
      op = 4'($urandom_range(0, 5));
      if (op == 4'd5) op = 4'($urandom_range(5, 15));
      send(op, rnd_operand(), rnd_operand());
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end
    rr_mode = 0;
    @(posedge clk);
    #1;
    wait_done();
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
